sprite_blit_addr_gen: RTL and testbench

//  Sequential sprite-to-framebuffer address generator. On start, walks every pixel of a
//  SPR_W x SPR_H sprite anchored at (pos_x,pos_y) and emits (spr_addr, frame_addr) pairs
//  on a valid/ready stream to the framebuffer write path. Off-screen pixels are clipped.

---
 rtl/sprite_blit_addr_gen_pkg.sv | 23 ++
 rtl/sprite_blit_addr_gen_if.sv | 15 +
 rtl/sprite_blit_addr_gen_raster_counter.sv | 61 ++++++
 rtl/sprite_blit_addr_gen.sv | 131 +++++++++++++
 tb/tb_sprite_blit_addr_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_blit_addr_gen_pkg.sv
// Shared defaults, FSM state encoding and coordinate types for the sprite blit address generator.
package sprite_blit_addr_gen_pkg;

    localparam int DEF_FRAME_W  = 640;
    localparam int DEF_FRAME_H  = 480;
    localparam int DEF_SPR_W    = 35;
    localparam int DEF_SPR_H    = 25;
    localparam int DEF_ANCHOR_X = 17;
    localparam int DEF_ANCHOR_Y = 12;
    localparam int DEF_POS_W    = 10;
    localparam int DEF_FADDR_W  = 19;
    localparam int DEF_SADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } blit_state_t;

    // Two extra bits: one for the sign, one for headroom past pos + SPR_W.
    typedef logic signed [DEF_POS_W+1:0] coord_t;

endpackage

// File: rtl/sprite_blit_addr_gen_if.sv
// Output beat stream: sprite ROM address paired with framebuffer address, valid/ready.
interface sprite_blit_addr_gen_if
    import sprite_blit_addr_gen_pkg::*;
#(
    parameter int SADDR_W = DEF_SADDR_W,
    parameter int FADDR_W = DEF_FADDR_W
);
    logic               out_valid;
    logic               out_ready;
    logic [SADDR_W-1:0] spr_addr;
    logic [FADDR_W-1:0] frame_addr;

    modport master (output out_valid, spr_addr, frame_addr, input  out_ready);
    modport slave  (input  out_valid, spr_addr, frame_addr, output out_ready);
endinterface

// File: rtl/sprite_blit_addr_gen_raster_counter.sv
// Raster walk over the sprite: col/row counters, last-pixel flag and per-row base addresses.
// Bases advance by a constant stride per row, so no multiplier sits in the pixel loop.
module blit_raster_counter
    import sprite_blit_addr_gen_pkg::*;
#(
    parameter int SPR_W   = DEF_SPR_W,
    parameter int SPR_H   = DEF_SPR_H,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int SADDR_W = DEF_SADDR_W,
    parameter int FB_W    = DEF_FADDR_W + 2,
    localparam int COL_W  = $clog2(SPR_W),
    localparam int ROW_W  = $clog2(SPR_H)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   advance_i,
    input  logic signed [FB_W-1:0] frame_base_init_i,
    output logic [COL_W-1:0]       col_o,
    output logic [ROW_W-1:0]       row_o,
    output logic                   last_o,
    output logic [SADDR_W-1:0]     spr_base_o,
    output logic signed [FB_W-1:0] frame_base_o
);
    logic [COL_W-1:0]       col_q;
    logic [ROW_W-1:0]       row_q;
    logic [SADDR_W-1:0]     spr_base_q;
    logic signed [FB_W-1:0] frame_base_q;
    logic                   end_of_row;

    assign end_of_row = (col_q == COL_W'(SPR_W - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q        <= '0;
            row_q        <= '0;
            spr_base_q   <= '0;
            frame_base_q <= '0;
        end else if (clear_i) begin
            col_q        <= '0;
            row_q        <= '0;
            spr_base_q   <= '0;
            frame_base_q <= frame_base_init_i;
        end else if (advance_i) begin
            if (end_of_row) begin
                col_q        <= '0;
                row_q        <= row_q + 1'b1;
                spr_base_q   <= spr_base_q + SADDR_W'(SPR_W);
                frame_base_q <= frame_base_q + FB_W'(FRAME_W);
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign last_o       = end_of_row && (row_q == ROW_W'(SPR_H - 1));
    assign spr_base_o   = spr_base_q;
    assign frame_base_o = frame_base_q;
endmodule

// File: rtl/sprite_blit_addr_gen.sv
// Sprite blit address generator: one pixel per advance, clipped pixels dropped, first beat 2 cycles
// after start; a single output register holds while out_ready is low and stalls the raster walk.
module sprite_blit_addr_gen
    import sprite_blit_addr_gen_pkg::*;
#(
    parameter int FRAME_W  = DEF_FRAME_W,
    parameter int FRAME_H  = DEF_FRAME_H,
    parameter int SPR_W    = DEF_SPR_W,
    parameter int SPR_H    = DEF_SPR_H,
    parameter int ANCHOR_X = DEF_ANCHOR_X,
    parameter int ANCHOR_Y = DEF_ANCHOR_Y,
    parameter int POS_W    = DEF_POS_W,
    parameter int FADDR_W  = DEF_FADDR_W,
    parameter int SADDR_W  = DEF_SADDR_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [POS_W-1:0] pos_x_i,
    input  logic [POS_W-1:0] pos_y_i,
    input  logic             flip_x_i,
    output logic             busy_o,
    output logic             done_o,
    sprite_blit_addr_gen_if.master out_if
);
    localparam int CW    = POS_W + 2;
    localparam int FB_W  = FADDR_W + 2;
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    blit_state_t        state_q;
    logic [POS_W-1:0]   pos_x_q, pos_y_q;
    logic               flip_q, busy_q, done_q, vld_q;
    logic [SADDR_W-1:0] spr_q;
    logic [FADDR_W-1:0] frame_q;

    logic [COL_W-1:0]       col, spr_col;
    logic [ROW_W-1:0]       row;
    logic                   last_px, accept, advance, clip;
    logic [SADDR_W-1:0]     spr_base;
    logic signed [FB_W-1:0] frame_base, fb_init;
    logic signed [CW-1:0]   x, y;

    assign accept  = (state_q == IDLE) && start_i && !done_q;
    assign advance = (state_q == RUN) && (!vld_q || out_if.out_ready);

    // Framebuffer address of screen column 0 on the sprite's top row; may be negative.
    assign fb_init = ($signed({{(FB_W-POS_W){1'b0}}, pos_y_i}) - FB_W'(ANCHOR_Y)) * FB_W'(FRAME_W);

    blit_raster_counter #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .FRAME_W (FRAME_W),
        .SADDR_W (SADDR_W),
        .FB_W    (FB_W)
    ) u_raster (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .clear_i           (accept),
        .advance_i         (advance),
        .frame_base_init_i (fb_init),
        .col_o             (col),
        .row_o             (row),
        .last_o            (last_px),
        .spr_base_o        (spr_base),
        .frame_base_o      (frame_base)
    );

    assign x = $signed({2'b00, pos_x_q}) + $signed({{(CW-COL_W){1'b0}}, col}) - CW'(ANCHOR_X);
    assign y = $signed({2'b00, pos_y_q}) + $signed({{(CW-ROW_W){1'b0}}, row}) - CW'(ANCHOR_Y);

    assign clip    = x[CW-1] || (x >= CW'(FRAME_W)) || y[CW-1] || (y >= CW'(FRAME_H));
    assign spr_col = flip_q ? (COL_W'(SPR_W - 1) - col) : col;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            flip_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            spr_q   <= '0;
            frame_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (vld_q && out_if.out_ready) begin
                vld_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pos_x_q <= pos_x_i;
                        pos_y_q <= pos_y_i;
                        flip_q  <= flip_x_i;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (!clip) begin
                            spr_q   <= spr_base + SADDR_W'(spr_col);
                            frame_q <= FADDR_W'(frame_base + FB_W'(x));
                            vld_q   <= 1'b1;
                        end
                        if (last_px) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave as soon as the final beat is (or was) taken this cycle.
                    if (!vld_q || out_if.out_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign out_if.out_valid  = vld_q;
    assign out_if.spr_addr   = spr_q;
    assign out_if.frame_addr = frame_q;
endmodule

// File: tb/tb_sprite_blit_addr_gen.sv
// Bench for sprite_blit_addr_gen: reference raster model feeds a scoreboard checked by a monitor.
module tb_sprite_blit_addr_gen;
    import sprite_blit_addr_gen_pkg::*;

    localparam int FW = DEF_FRAME_W;
    localparam int FH = DEF_FRAME_H;
    localparam int SW = DEF_SPR_W;
    localparam int SH = DEF_SPR_H;
    localparam int AX = DEF_ANCHOR_X;
    localparam int AY = DEF_ANCHOR_Y;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [DEF_POS_W-1:0] pos_x, pos_y;
    logic                 flip;
    logic                 busy, done;

    sprite_blit_addr_gen_if bus ();

    sprite_blit_addr_gen dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .pos_x_i  (pos_x),
        .pos_y_i  (pos_y),
        .flip_x_i (flip),
        .busy_o   (busy),
        .done_o   (done),
        .out_if   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int spr;
        int frame;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    errors   = 0;
    int    checks   = 0;
    int    done_cnt = 0;
    bit    rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: every sprite pixel in raster order, kept only if it lands on screen.
    task automatic model(input int px, input int py, input bit fl);
        for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
                int sx = px + c - AX;
                int sy = py + r - AY;
                if (sx >= 0 && sx < FW && sy >= 0 && sy < FH)
                    exp_q.push_back('{r * SW + (fl ? SW - 1 - c : c), sy * FW + sx});
            end
        end
    endtask

    task automatic monitor_loop();
        bit    stall = 1'b0;
        int    h_spr = 0, h_frame = 0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_spr", int'(bus.spr_addr), h_spr);
                chk("hold_frame", int'(bus.frame_addr), h_frame);
            end
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back('{int'(bus.spr_addr), int'(bus.frame_addr)});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got spr %0d frame %0d, expected no beat",
                             bus.spr_addr, bus.frame_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_spr", int'(bus.spr_addr), e.spr);
                    chk("beat_frame", int'(bus.frame_addr), e.frame);
                end
            end
            stall   = bus.out_valid && !bus.out_ready;
            h_spr   = int'(bus.spr_addr);
            h_frame = int'(bus.frame_addr);
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic run_blit(input int px, input int py, input bit fl, input bit lat,
                            input int stall_at, input int restart_at, input bit start_at_done,
                            output int idx);
        int d0, n;
        @(posedge clk);
        #1;
        model(px, py, fl);
        d0  = done_cnt;
        idx = obs_q.size();
        pos_x = DEF_POS_W'(px);
        pos_y = DEF_POS_W'(py);
        flip  = fl;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (lat) begin
            chk("lat_busy_c1", int'(busy), 1);
            chk("lat_valid_c1", int'(bus.out_valid), 0);
            @(posedge clk);
            #1;
            chk("lat_valid_c2", int'(bus.out_valid), 1);
        end
        if (stall_at > 0) begin
            repeat (stall_at) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
        end
        if (restart_at > 0) begin
            repeat (restart_at) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", n);
        end else if (start_at_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("busy_after_done", int'(busy), 0);
        chk("scoreboard_leftover", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_ends(input string tag, input int idx, input int cnt,
                              input int fs, input int ff, input int ls, input int lf);
        chk({tag, "_count"}, obs_q.size() - idx, cnt);
        if (obs_q.size() > idx) begin
            chk({tag, "_first_spr"}, obs_q[idx].spr, fs);
            chk({tag, "_first_frame"}, obs_q[idx].frame, ff);
            chk({tag, "_last_spr"}, obs_q[obs_q.size() - 1].spr, ls);
            chk({tag, "_last_frame"}, obs_q[obs_q.size() - 1].frame, lf);
        end
    endtask

    initial begin
        int idx;
        rst_n = 1'b0;
        start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        flip  = 1'b0;
        bus.out_ready = 1'b1;
        fork
            monitor_loop();
            ready_loop();
        join_none
        #23;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_spr", int'(bus.spr_addr), 0);
        chk("rst_frame", int'(bus.frame_addr), 0);
        rst_n = 1'b1;

        run_blit(100, 50, 1'b0, 1'b1, 0, 0, 1'b0, idx);
        check_ends("c1", idx, 875, 0, 24403, 874, 39797);

        run_blit(5, 50, 1'b0, 1'b0, 0, 0, 1'b0, idx);
        check_ends("c2", idx, 575, 12, 24320, 874, 39797 - 95);

        run_blit(100, 50, 1'b1, 1'b0, 0, 0, 1'b0, idx);
        check_ends("c3", idx, 875, 34, 24403, 840, 39797);

        run_blit(100, 50, 1'b0, 1'b0, 100, 0, 1'b0, idx);
        check_ends("c4", idx, 875, 0, 24403, 874, 39797);

        run_blit(700, 600, 1'b0, 1'b0, 0, 200, 1'b1, idx);
        chk("c5_count", obs_q.size() - idx, 0);

        // Reset in the middle of a blit, then a clean restart.
        @(posedge clk);
        #1;
        model(100, 50, 1'b0);
        pos_x = 10'd100;
        pos_y = 10'd50;
        flip  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("c6_rst_valid", int'(bus.out_valid), 0);
        chk("c6_rst_busy", int'(busy), 0);
        chk("c6_rst_done", int'(done), 0);
        chk("c6_rst_frame", int'(bus.frame_addr), 0);
        exp_q.delete();
        #7;
        rst_n = 1'b1;
        run_blit(100, 50, 1'b0, 1'b0, 0, 0, 1'b0, idx);
        check_ends("c6", idx, 875, 0, 24403, 874, 39797);

        // Randomised positions and backpressure, plus the screen corners.
        rand_ready = 1'b1;
        run_blit(0, 0, 1'b1, 1'b0, 0, 0, 1'b0, idx);
        run_blit(639, 479, 1'b0, 1'b0, 0, 0, 1'b0, idx);
        for (int i = 0; i < 6; i++) begin
            run_blit(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)),
                     1'(($urandom_range(0, 1))), 1'b0, 0, 0, 1'b0, idx);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
